// File: rtl/kb_tx_pkg.sv
// Shared types and constants for the keyboard/aux -> UART TX arbiter.
// The optional CR -> CR,LF expansion is enabled by the KB_TX_CRLF_EN macro.
package kb_tx_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        SEND_LF = 2'd2
    } state_e;

    // Source identifiers; these are also the o_grant encoding.
    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_KB   = 2'b01;
    localparam logic [1:0] SRC_AUX  = 2'b10;

    // ASCII codes with special meaning to the arbiter.
    localparam logic [7:0] ASCII_NUL = 8'h00;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

endpackage

// File: rtl/kb_tx_stall_timer.sv
// Saturating counter of consecutive "UART full while holding a byte" cycles.
// o_stall is high once the count reaches STALL_MAX; clear has priority.
module kb_tx_stall_timer #(
    parameter int unsigned STALL_MAX = 100_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_count,
    output logic o_stall
);

    localparam int unsigned CNT_W = $clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_MAX);

    logic [CNT_W-1:0] count_reg;

    // Count blocked cycles, stop at CNT_MAX, drop back to zero on clear.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            count_reg <= '0;
        end else if (i_count && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign o_stall = (count_reg == CNT_MAX);

endmodule

// File: rtl/kb_tx_arbiter.sv
// Round-robin arbiter feeding the UART TX FIFO from the keyboard ASCII path
// and an auxiliary valid/ready byte source. A source is popped only from IDLE,
// the byte is parked in hold_reg and written once the UART has room.
// Optional feature macro: KB_TX_CRLF_EN (keyboard CR is sent as CR then LF).
module kb_tx_arbiter
    import kb_tx_pkg::*;
#(
    parameter int unsigned STALL_MAX = 100_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_kb_buf_empty,
    input  logic [7:0] i_kb_ascii,
    output logic       o_rd_key_code,
    input  logic       i_aux_valid,
    input  logic [7:0] i_aux_data,
    output logic       o_aux_ready,
    input  logic       i_tx_full,
    output logic       o_wr_uart,
    output logic [7:0] o_wr_data,
    output logic       o_stall,
    output logic [1:0] o_grant
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_SEND    = SEND;
    localparam logic [1:0] ST_SEND_LF = SEND_LF;

    logic [1:0] state_reg,   state_next;
    logic [7:0] hold_reg,    hold_next;
    logic [1:0] owner_reg,   owner_next;
    logic [1:0] rr_last_reg, rr_last_next;

    logic in_idle;
    logic busy;
    logic lf_phase;
    logic pick_kb;
    logic pick_aux;
    logic write_en;
    logic stall_raw;

    // Arbitration and write qualification; pops never look at i_tx_full.
    always_comb begin
        in_idle  = (state_reg == ST_IDLE);
        lf_phase = (state_reg == ST_SEND_LF);
        busy     = (state_reg == ST_SEND) || lf_phase;
        pick_kb  = in_idle && !i_kb_buf_empty
                   && (!i_aux_valid || (rr_last_reg == SRC_AUX));
        pick_aux = in_idle && i_aux_valid && !pick_kb;
        write_en = busy && !i_tx_full;
    end

    // Next-state logic: latch the winner, hold until the UART accepts it.
    always_comb begin
        state_next   = state_reg;
        hold_next    = hold_reg;
        owner_next   = owner_reg;
        rr_last_next = rr_last_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_kb) begin
                    rr_last_next = SRC_KB;
                    // Unmapped keys are popped and dropped without a write.
                    if (i_kb_ascii != ASCII_NUL) begin
                        hold_next  = i_kb_ascii;
                        owner_next = SRC_KB;
                        state_next = ST_SEND;
                    end
                end else if (pick_aux) begin
                    rr_last_next = SRC_AUX;
                    hold_next    = i_aux_data;
                    owner_next   = SRC_AUX;
                    state_next   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!i_tx_full) begin
                    state_next = ST_IDLE;
`ifdef KB_TX_CRLF_EN
                    if ((owner_reg == SRC_KB) && (hold_reg == ASCII_CR)) begin
                        state_next = ST_SEND_LF;
                    end
`endif
                end
            end
`ifdef KB_TX_CRLF_EN
            ST_SEND_LF: begin
                if (!i_tx_full) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers; rr_last starts at aux so the keyboard wins the first tie.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg   <= ST_IDLE;
            hold_reg    <= ASCII_NUL;
            owner_reg   <= SRC_NONE;
            rr_last_reg <= SRC_AUX;
        end else begin
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            owner_reg   <= owner_next;
            rr_last_reg <= rr_last_next;
        end
    end

    kb_tx_stall_timer #(
        .STALL_MAX (STALL_MAX)
    ) u_stall_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (!busy || write_en),
        .i_count (busy && i_tx_full),
        .o_stall (stall_raw)
    );

    // Outputs are forced low while reset is asserted.
    assign o_rd_key_code = pick_kb  && !i_reset;
    assign o_aux_ready   = pick_aux && !i_reset;
    assign o_wr_uart     = write_en && !i_reset;
    assign o_wr_data     = i_reset  ? ASCII_NUL : (lf_phase ? ASCII_LF : hold_reg);
    assign o_stall       = stall_raw && !i_reset;
    assign o_grant       = (busy && !i_reset) ? owner_reg : SRC_NONE;

endmodule

// File: tb/tb_kb_tx_arbiter.sv
// Self-checking bench for kb_tx_arbiter: a vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_kb_tx_arbiter;

    localparam int STALL_MAX = 8;
`ifdef KB_TX_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic       i_clk;
    logic       i_reset;
    logic       i_kb_buf_empty;
    logic [7:0] i_kb_ascii;
    logic       o_rd_key_code;
    logic       i_aux_valid;
    logic [7:0] i_aux_data;
    logic       o_aux_ready;
    logic       i_tx_full;
    logic       o_wr_uart;
    logic [7:0] o_wr_data;
    logic       o_stall;
    logic [1:0] o_grant;

    kb_tx_arbiter #(
        .STALL_MAX (STALL_MAX)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_kb_buf_empty (i_kb_buf_empty),
        .i_kb_ascii     (i_kb_ascii),
        .o_rd_key_code  (o_rd_key_code),
        .i_aux_valid    (i_aux_valid),
        .i_aux_data     (i_aux_data),
        .o_aux_ready    (o_aux_ready),
        .i_tx_full      (i_tx_full),
        .o_wr_uart      (o_wr_uart),
        .o_wr_data      (o_wr_data),
        .o_stall        (o_stall),
        .o_grant        (o_grant)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Apply inputs mid-cycle (after the negedge) and let combinational outputs settle.
    task automatic drive(input logic rst, input logic kb_empty, input logic [7:0] kb_ascii,
                         input logic aux_v, input logic [7:0] aux_d, input logic full);
        @(negedge i_clk);
        i_reset        = rst;
        i_kb_buf_empty = kb_empty;
        i_kb_ascii     = kb_ascii;
        i_aux_valid    = aux_v;
        i_aux_data     = aux_d;
        i_tx_full      = full;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic rd, input logic ardy, input logic wr,
                              input logic [7:0] data, input logic [1:0] grant, input logic stall);
        $display("%s: rd=%0b ardy=%0b wr=%0b data=%02h grant=%0d stall=%0b",
                 tag, o_rd_key_code, o_aux_ready, o_wr_uart, o_wr_data, o_grant, o_stall);
        check({tag, " rd_key_code"}, o_rd_key_code, rd);
        check({tag, " aux_ready"},   o_aux_ready,   ardy);
        check({tag, " wr_uart"},     o_wr_uart,     wr);
        check({tag, " grant"},       o_grant,       grant);
        check({tag, " stall"},       o_stall,       stall);
        if (wr) check({tag, " wr_data"}, o_wr_data, data);
    endtask

    typedef struct {
        logic       rst;
        logic       kb_empty;
        logic [7:0] kb_ascii;
        logic       aux_v;
        logic [7:0] aux_d;
        logic       full;
        logic       rd;
        logic       ardy;
        logic       wr;
        logic [7:0] data;
        logic [1:0] grant;
    } vec_t;

    vec_t vecs[$];

    // Reference model state for the randomized run.
    logic [7:0] kbq[$];
    logic [7:0] auxq[$];
    logic [7:0] exp_b[$];
    logic [1:0] exp_s[$];
    bit         last_aux;
    int         run;

    function automatic logic [7:0] rand_key();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 8'h00;
        if (r == 1) return 8'h0D;
        return 8'(8'h20 + $urandom_range(0, 94));
    endfunction

    initial begin
        i_reset = 1'b1; i_kb_buf_empty = 1'b1; i_kb_ascii = 8'h00;
        i_aux_valid = 1'b0; i_aux_data = 8'h00; i_tx_full = 1'b0;

        // ---------------- reset state ----------------
        drive(1, 1, 8'h00, 0, 8'h00, 0);
        drive(1, 0, 8'h41, 1, 8'h42, 0);
        expect_out("reset", 0, 0, 0, 8'h00, 2'd0, 0);

        // ---------------- vector table ----------------
        //                   rst kbE kbA    auxV auxD   full rd ardy wr data   grant
        vecs.push_back(vec_t'{0, 0, 8'h41, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2'd0}); // kb 'A' pop
        vecs.push_back(vec_t'{0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'h41, 2'd1}); // written next cycle
        vecs.push_back(vec_t'{0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'd0});
        vecs.push_back(vec_t'{1, 0, 8'h61, 1, 8'h58, 0, 0, 0, 0, 8'h00, 2'd0}); // reset, rr -> aux
        vecs.push_back(vec_t'{0, 0, 8'h61, 1, 8'h58, 0, 1, 0, 0, 8'h00, 2'd0}); // tie: kb first
        vecs.push_back(vec_t'{0, 0, 8'h62, 1, 8'h58, 0, 0, 0, 1, 8'h61, 2'd1});
        vecs.push_back(vec_t'{0, 0, 8'h62, 1, 8'h58, 0, 0, 1, 0, 8'h00, 2'd0}); // tie: aux
        vecs.push_back(vec_t'{0, 0, 8'h62, 1, 8'h59, 0, 0, 0, 1, 8'h58, 2'd2});
        vecs.push_back(vec_t'{0, 0, 8'h62, 1, 8'h59, 0, 1, 0, 0, 8'h00, 2'd0}); // tie: kb
        vecs.push_back(vec_t'{0, 1, 8'h00, 1, 8'h59, 0, 0, 0, 1, 8'h62, 2'd1});
        vecs.push_back(vec_t'{0, 1, 8'h00, 1, 8'h59, 0, 0, 1, 0, 8'h00, 2'd0});
        vecs.push_back(vec_t'{0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'h59, 2'd2});
        vecs.push_back(vec_t'{0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2'd0}); // unmapped popped
        vecs.push_back(vec_t'{0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'd0}); // no write
        vecs.push_back(vec_t'{0, 0, 8'h63, 0, 8'h00, 0, 1, 0, 0, 8'h00, 2'd0}); // still IDLE
        vecs.push_back(vec_t'{0, 1, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 2'd1}); // full: wait
        vecs.push_back(vec_t'{0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'h63, 2'd1});
        vecs.push_back(vec_t'{0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'd0});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].kb_empty, vecs[i].kb_ascii,
                  vecs[i].aux_v, vecs[i].aux_d, vecs[i].full);
            expect_out($sformatf("vec%0d", i), vecs[i].rd, vecs[i].ardy, vecs[i].wr,
                       vecs[i].data, vecs[i].grant, 1'b0);
        end

        // ---------------- UART full for 10 cycles, stall flag ----------------
        drive(1, 1, 8'h00, 0, 8'h00, 0);
        drive(0, 0, 8'h41, 0, 8'h00, 0);
        expect_out("full pop", 1, 0, 0, 8'h00, 2'd0, 0);
        for (int k = 1; k <= 10; k++) begin
            drive(0, 0, 8'h42, 1, 8'h5A, 1);
            expect_out($sformatf("full cyc%0d", k), 0, 0, 0, 8'h00, 2'd1, (k >= 9));
        end
        drive(0, 0, 8'h42, 1, 8'h5A, 0);
        expect_out("full release", 0, 0, 1, 8'h41, 2'd1, 1);
        drive(0, 0, 8'h42, 1, 8'h5A, 0);
        expect_out("after release", 0, 1, 0, 8'h00, 2'd0, 0);
        drive(0, 1, 8'h00, 0, 8'h00, 0);
        expect_out("aux after full", 0, 0, 1, 8'h5A, 2'd2, 0);

        // ---------------- CR handling ----------------
        drive(1, 1, 8'h00, 0, 8'h00, 0);
        drive(0, 0, 8'h0D, 0, 8'h00, 0);
        expect_out("kb cr pop", 1, 0, 0, 8'h00, 2'd0, 0);
        drive(0, 1, 8'h00, 0, 8'h00, 0);
        expect_out("kb cr write", 0, 0, 1, 8'h0D, 2'd1, 0);
        drive(0, 1, 8'h00, 0, 8'h00, 0);
        expect_out("kb cr lf", 0, 0, CRLF, 8'h0A, CRLF ? 2'd1 : 2'd0, 0);
        drive(0, 1, 8'h00, 0, 8'h00, 0);
        expect_out("kb cr done", 0, 0, 0, 8'h00, 2'd0, 0);
        drive(0, 1, 8'h00, 1, 8'h0D, 0);
        expect_out("aux cr pop", 0, 1, 0, 8'h00, 2'd0, 0);
        drive(0, 1, 8'h00, 0, 8'h00, 0);
        expect_out("aux cr write", 0, 0, 1, 8'h0D, 2'd2, 0);
        drive(0, 1, 8'h00, 0, 8'h00, 0);
        expect_out("aux cr single", 0, 0, 0, 8'h00, 2'd0, 0);

        // ---------------- reset mid-SEND ----------------
        drive(0, 0, 8'h51, 0, 8'h00, 0);
        expect_out("mid pop", 1, 0, 0, 8'h00, 2'd0, 0);
        drive(0, 1, 8'h00, 0, 8'h00, 1);
        expect_out("mid hold", 0, 0, 0, 8'h00, 2'd1, 0);
        drive(1, 0, 8'h52, 1, 8'h53, 0);
        expect_out("mid reset", 0, 0, 0, 8'h00, 2'd0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 8'h00, 0, 8'h00, 0);
            expect_out($sformatf("post reset%0d", k), 0, 0, 0, 8'h00, 2'd0, 0);
        end

        // ---------------- randomized run vs. reference model ----------------
        drive(1, 1, 8'h00, 0, 8'h00, 0);
        last_aux = 1'b1;
        run      = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            bit full;
            bit busy, e_wr, e_rd, e_ardy, kr, ar;
            logic [1:0] e_grant;
            logic [7:0] b;
            if (cyc < 600) begin
                if ($urandom_range(0, 3) == 0) kbq.push_back(rand_key());
                if ($urandom_range(0, 4) == 0) auxq.push_back(($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom));
                full = ($urandom_range(0, 9) < 3) || (cyc >= 200 && cyc < 215);
            end else begin
                full = 1'b0;
            end
            drive(0, kbq.size() == 0, (kbq.size() != 0) ? kbq[0] : 8'hEE,
                  auxq.size() != 0, (auxq.size() != 0) ? auxq[0] : 8'hEE, full);

            busy    = (exp_b.size() != 0);
            e_wr    = busy && !full;
            e_grant = busy ? exp_s[0] : 2'd0;
            kr      = !busy && (kbq.size() != 0);
            ar      = !busy && (auxq.size() != 0);
            e_rd    = kr && (!ar || last_aux);
            e_ardy  = ar && !e_rd;

            check("rnd rd_key_code", o_rd_key_code, e_rd);
            check("rnd aux_ready",   o_aux_ready,   e_ardy);
            check("rnd wr_uart",     o_wr_uart,     e_wr);
            check("rnd grant",       o_grant,       e_grant);
            check("rnd stall",       o_stall,       (run == STALL_MAX));

            if (e_wr) begin
                check("rnd wr_data", o_wr_data, exp_b[0]);
                $display("rnd cyc%0d write %02h src %0d", cyc, o_wr_data, exp_s[0]);
                void'(exp_b.pop_front());
                void'(exp_s.pop_front());
            end
            run = (busy && full) ? ((run < STALL_MAX) ? run + 1 : run) : 0;
            if (e_rd) begin
                b = kbq.pop_front();
                last_aux = 1'b0;
                if (b != 8'h00) begin
                    exp_b.push_back(b); exp_s.push_back(2'd1);
                end
                if (CRLF && b == 8'h0D) begin
                    exp_b.push_back(8'h0A); exp_s.push_back(2'd1);
                end
            end
            if (e_ardy) begin
                b = auxq.pop_front();
                last_aux = 1'b1;
                exp_b.push_back(b); exp_s.push_back(2'd2);
            end
        end
        check("rnd drained out",  exp_b.size(), 0);
        check("rnd drained kb",   kbq.size(),   0);
        check("rnd drained aux",  auxq.size(),  0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
